// File: rtl/irq_redirect_ctrl.sv
// Interrupt entry/return sequencer beside EX: synchronises and masks IRQ lines, drains the
// pipeline with NOP-hold cycles, saves EPC, then steers fetch to the handler or back to EPC.
module irq_redirect_ctrl #(
    parameter int          N_IRQ        = 4,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0800,
    parameter int          VEC_STRIDE   = 16,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ex_valid,
    input  logic [31:0]      pc_ex,
    input  logic             jp_pending,
    input  logic             eret,
    output logic             int_nop,
    output logic             pc_load,
    output logic             irq_ret,
    output logic [31:0]      pc_new,
    output logic [31:0]      epc,
    output logic [2:0]       cause,
    output logic             in_isr,
    output logic [N_IRQ-1:0] mask,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_REDIRECT = 3'd2,
        S_ISR      = 3'd3,
        S_RETURN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] irq_meta, irq_s, mask_q, pend;
    logic [31:0]      epc_q;
    logic [2:0]       cause_q, take_idx, drain_q;
    logic             take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta <= '0;
            irq_s    <= '0;
            mask_q   <= '0;
        end else begin
            irq_meta <= irq_in;
            irq_s    <= irq_meta;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign pend = irq_s & mask_q;

    // Fixed priority: the lowest pending index wins.
    always_comb begin
        take_idx = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) take_idx = 3'(i);
        end
    end

    // EX must hold a real instruction whose PC can be replayed; a resolving branch or an
    // ERET in EX defers the take until EX holds a plain instruction.
    assign take = (state_q == S_IDLE) && (|pend) && ex_valid && !jp_pending && !eret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                epc_q   <= pc_ex;
                cause_q <= take_idx;
                drain_q <= 3'(DRAIN_CYCLES);
            end else if (state_q == S_DRAIN) begin
                drain_q <= drain_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        int_nop = 1'b0;
        pc_load = 1'b0;
        irq_ret = 1'b0;
        pc_new  = '0;
        in_isr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                int_nop = 1'b1;
                if (drain_q <= 3'd1) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                pc_load = 1'b1;
                pc_new  = HANDLER_BASE + ({29'd0, cause_q} * 32'(VEC_STRIDE));
                state_d = S_ISR;
            end
            S_ISR: begin
                in_isr = 1'b1;
                if (eret && ex_valid) state_d = S_RETURN;
            end
            S_RETURN: begin
                irq_ret = 1'b1;
                pc_new  = epc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign epc       = epc_q;
    assign cause     = cause_q;
    assign mask      = mask_q;
    assign dbg_state = state_q;

endmodule
